// File: rtl/multicycle_control_sequencer_pkg.sv
// Shared types and constants for the multicycle control sequencer.
package multicycle_control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL_FETCH = 3'd0,
    ST_FETCH_EXECUTE = 3'd1,
    ST_MEM_WAIT      = 3'd2,
    ST_COMPLETE      = 3'd3,
    ST_HALT          = 3'd4
  } ControlState_t;

  typedef enum logic [2:0] {
    HALT_NONE          = 3'd0,
    HALT_ECALL         = 3'd1,
    HALT_PC_MISALIGNED = 3'd2,
    HALT_MEM_UNALIGNED = 3'd3,
    HALT_BAD_OPCODE    = 3'd4,
    HALT_TIMEOUT       = 3'd5
  } HaltCause_t;

  typedef enum logic [1:0] {
    RD_MEMORY    = 2'd0,
    RD_ALU       = 2'd1,
    RD_IMMEDIATE = 2'd2,
    RD_BRANCH    = 2'd3
  } RdSource_t;

  typedef enum logic [1:0] {
    MEM_NOP           = 2'd0,
    MEM_LOAD          = 2'd1,
    MEM_STORE_PRELOAD = 2'd2,
    MEM_STORE         = 2'd3
  } MemoryMode_t;

  localparam logic IAS_CURRENT_PC = 1'b0;
  localparam logic IAS_NEXT_PC    = 1'b1;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // sb/sh need the old word merged in; sw writes the whole word directly.
  function automatic logic is_subword_store(input logic [2:0] f3);
    return (f3 != FUNCT3_WORD);
  endfunction

  // Resolve simultaneous halt events to a single recorded cause.
  function automatic HaltCause_t pick_halt_cause(
    input logic pc_mis,
    input logic mem_unal,
    input logic timeout,
    input logic bad_op,
    input logic ecall
  );
    if (pc_mis)        return HALT_PC_MISALIGNED;
    else if (mem_unal) return HALT_MEM_UNALIGNED;
    else if (timeout)  return HALT_TIMEOUT;
    else if (bad_op)   return HALT_BAD_OPCODE;
    else if (ecall)    return HALT_ECALL;
    else               return HALT_NONE;
  endfunction

endpackage

// File: rtl/multicycle_control_sequencer_memory_wait_timer.sv
// Counts memory wait cycles and flags the last permitted one.
module multicycle_control_sequencer_memory_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a completed access never leaves a stale count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/multicycle_control_sequencer.sv
// Instruction control FSM: single/multi-cycle sequencing, memory wait
// handshake with watchdog, error-gated commits, sticky halt cause and
// retired-instruction counter.
//
//   state          | meaning
//   INITIAL_FETCH  | first cycle after reset, nothing committed
//   FETCH_EXECUTE  | decode; commit single-cycle ops or issue memory op
//   MEM_WAIT       | holding memory request until memory_ready
//   COMPLETE       | commit load data / final store, advance PC
//   HALT           | stopped until reset
module multicycle_control_sequencer
  import multicycle_control_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES    = 15,
  parameter bit SUBWORD_STORE_RMW = 1'b1,
  parameter int RETIRE_WIDTH      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    memory_ready,
  input  logic                    pc_misaligned,
  input  logic                    memory_unaligned,
  output logic                    rd_write_enable,
  output logic [1:0]              rd_source,
  output logic [1:0]              memory_mode,
  output logic                    pc_write_enable,
  output logic                    instruction_address_source,
  output logic                    halted,
  output logic [2:0]              halt_cause,
  output logic [RETIRE_WIDTH-1:0] retired_count
);

  ControlState_t           state_q, state_d;
  MemoryMode_t             pending_mode_q, pending_mode_d;
  HaltCause_t              halt_cause_q, halt_cause_d;
  logic [RETIRE_WIDTH-1:0] retired_count_q, retired_count_d;

  logic        rd_we;
  RdSource_t   rd_src;
  MemoryMode_t mem_mode;
  logic        pc_we;
  logic        ias;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;
  logic        ecall_req;
  logic        bad_opcode_req;
  logic        timeout_req;
  logic        halt_entry;

  multicycle_control_sequencer_memory_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Next-state and output decode; a halt trigger overrides every commit.
  always_comb begin
    state_d        = state_q;
    pending_mode_d = pending_mode_q;
    halt_cause_d   = halt_cause_q;
    rd_we          = 1'b0;
    rd_src         = RD_ALU;
    mem_mode       = MEM_NOP;
    pc_we          = 1'b0;
    ias            = IAS_CURRENT_PC;
    timer_clear    = 1'b1;
    timer_enable   = 1'b0;
    ecall_req      = 1'b0;
    bad_opcode_req = 1'b0;
    timeout_req    = 1'b0;

    case (state_q)
      ST_INITIAL_FETCH: begin
        state_d = ST_FETCH_EXECUTE;
      end

      ST_FETCH_EXECUTE: begin
        case (opcode)
          OPCODE_LOAD: begin
            mem_mode       = MEM_LOAD;
            pending_mode_d = MEM_LOAD;
            state_d        = ST_MEM_WAIT;
          end
          OPCODE_STORE: begin
            if (SUBWORD_STORE_RMW && is_subword_store(funct3)) begin
              mem_mode       = MEM_STORE_PRELOAD;
              pending_mode_d = MEM_STORE_PRELOAD;
              state_d        = ST_MEM_WAIT;
            end else begin
              mem_mode = MEM_STORE;
              pc_we    = 1'b1;
              ias      = IAS_NEXT_PC;
            end
          end
          OPCODE_LUI, OPCODE_AUIPC: begin
            rd_we  = 1'b1;
            rd_src = RD_IMMEDIATE;
            pc_we  = 1'b1;
            ias    = IAS_NEXT_PC;
          end
          OPCODE_JAL, OPCODE_JALR: begin
            rd_we  = 1'b1;
            rd_src = RD_BRANCH;
            pc_we  = 1'b1;
            ias    = IAS_NEXT_PC;
          end
          OPCODE_OP, OPCODE_OP_IMM: begin
            rd_we  = 1'b1;
            rd_src = RD_ALU;
            pc_we  = 1'b1;
            ias    = IAS_NEXT_PC;
          end
          OPCODE_BRANCH, OPCODE_MISC_MEM: begin
            pc_we = 1'b1;
            ias   = IAS_NEXT_PC;
          end
          OPCODE_SYSTEM: begin
            ecall_req = 1'b1;
          end
          default: begin
            bad_opcode_req = 1'b1;
          end
        endcase
      end

      ST_MEM_WAIT: begin
        mem_mode = pending_mode_q;
        if (memory_ready) begin
          state_d = ST_COMPLETE;
        end else begin
          timer_clear  = 1'b0;
          timer_enable = 1'b1;
          timeout_req  = timer_expired;
        end
      end

      ST_COMPLETE: begin
        if (pending_mode_q == MEM_LOAD) begin
          rd_we    = 1'b1;
          rd_src   = RD_MEMORY;
          mem_mode = MEM_LOAD;
        end else begin
          mem_mode = MEM_STORE;
        end
        pc_we   = 1'b1;
        ias     = IAS_NEXT_PC;
        state_d = ST_FETCH_EXECUTE;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_INITIAL_FETCH;
      end
    endcase

    halt_entry = (state_q != ST_HALT) &&
                 (pc_misaligned || memory_unaligned || ecall_req ||
                  bad_opcode_req || timeout_req);

    if (halt_entry) begin
      rd_we        = 1'b0;
      pc_we        = 1'b0;
      mem_mode     = MEM_NOP;
      ias          = IAS_CURRENT_PC;
      timer_clear  = 1'b1;
      timer_enable = 1'b0;
      state_d      = ST_HALT;
      halt_cause_d = pick_halt_cause(pc_misaligned, memory_unaligned,
                                     timeout_req, bad_opcode_req, ecall_req);
    end
  end

  // Retired counter advances on every PC commit and wraps naturally.
  always_comb begin
    retired_count_d = retired_count_q;
    if (pc_we) begin
      retired_count_d = retired_count_q + RETIRE_WIDTH'(1);
    end
  end

  // State, pending access kind, halt cause and retired count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_INITIAL_FETCH;
      pending_mode_q  <= MEM_NOP;
      halt_cause_q    <= HALT_NONE;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      pending_mode_q  <= pending_mode_d;
      halt_cause_q    <= halt_cause_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign rd_write_enable            = rd_we;
  assign rd_source                  = rd_src;
  assign memory_mode                = mem_mode;
  assign pc_write_enable            = pc_we;
  assign instruction_address_source = ias;
  assign halted                     = (state_q == ST_HALT);
  assign halt_cause                 = halt_cause_q;
  assign retired_count              = retired_count_q;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Directed bench: instance A uses default parameters, instance B uses
// TIMEOUT_CYCLES=4, SUBWORD_STORE_RMW=0, RETIRE_WIDTH=4.
module tb_multicycle_control_sequencer;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic clock;
  logic reset;

  logic [6:0] a_opcode, b_opcode;
  logic [2:0] a_funct3, b_funct3;
  logic       a_ready, b_ready, a_pcmis, b_pcmis, a_memun, b_memun;

  logic       a_rd_we, a_pc_we, a_ias, a_halted;
  logic [1:0] a_rd_src, a_mem;
  logic [2:0] a_cause;
  logic [31:0] a_retired;

  logic       b_rd_we, b_pc_we, b_ias, b_halted;
  logic [1:0] b_rd_src, b_mem;
  logic [2:0] b_cause;
  logic [3:0] b_retired;

  int checks = 0;
  int errors = 0;

  multicycle_control_sequencer dut_a (
    .clock(clock), .reset(reset), .opcode(a_opcode), .funct3(a_funct3),
    .memory_ready(a_ready), .pc_misaligned(a_pcmis), .memory_unaligned(a_memun),
    .rd_write_enable(a_rd_we), .rd_source(a_rd_src), .memory_mode(a_mem),
    .pc_write_enable(a_pc_we), .instruction_address_source(a_ias),
    .halted(a_halted), .halt_cause(a_cause), .retired_count(a_retired)
  );

  multicycle_control_sequencer #(
    .TIMEOUT_CYCLES(4), .SUBWORD_STORE_RMW(1'b0), .RETIRE_WIDTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .opcode(b_opcode), .funct3(b_funct3),
    .memory_ready(b_ready), .pc_misaligned(b_pcmis), .memory_unaligned(b_memun),
    .rd_write_enable(b_rd_we), .rd_source(b_rd_src), .memory_mode(b_mem),
    .pc_write_enable(b_pc_we), .instruction_address_source(b_ias),
    .halted(b_halted), .halt_cause(b_cause), .retired_count(b_retired)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive instance A for one cycle; outputs settle 1 time unit after the negedge.
  task automatic apply_a(input logic [6:0] op, input logic [2:0] f3,
                         input logic rdy, input logic pm, input logic mu);
    @(negedge clock);
    a_opcode = op; a_funct3 = f3; a_ready = rdy; a_pcmis = pm; a_memun = mu;
    #1;
  endtask

  task automatic apply_b(input logic [6:0] op, input logic [2:0] f3,
                         input logic rdy, input logic pm, input logic mu);
    @(negedge clock);
    b_opcode = op; b_funct3 = f3; b_ready = rdy; b_pcmis = pm; b_memun = mu;
    #1;
  endtask

  // Pulse reset in the low clock phase; both instances leave in INITIAL_FETCH.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    a_opcode = OP_FENCE; a_funct3 = 3'd0; a_ready = 1'b0; a_pcmis = 1'b0; a_memun = 1'b0;
    b_opcode = OP_FENCE; b_funct3 = 3'd0; b_ready = 1'b0; b_pcmis = 1'b0; b_memun = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_opcode = OP_OPIMM; a_funct3 = 3'd0; a_ready = 1'b0; a_pcmis = 1'b0; a_memun = 1'b0;
    b_opcode = OP_OPIMM; b_funct3 = 3'd0; b_ready = 1'b0; b_pcmis = 1'b0; b_memun = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (a_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we: got %b expected 0", a_rd_we); end
    checks++; if (a_pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we: got %b expected 0", a_pc_we); end
    checks++; if (a_mem !== 2'd0) begin errors++; $display("FAIL reset_mem_mode: got %0d expected 0", a_mem); end
    checks++; if (a_ias !== 1'b0) begin errors++; $display("FAIL reset_ias: got %b expected 0", a_ias); end
    checks++; if (a_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", a_halted); end
    checks++; if (a_cause !== 3'd0) begin errors++; $display("FAIL reset_cause: got %0d expected 0", a_cause); end
    checks++; if (a_retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", a_retired); end
  endtask

  task automatic test_addi();
    do_reset();
    a_opcode = OP_OPIMM;
    #1;
    checks++; if (a_rd_we !== 1'b0 || a_pc_we !== 1'b0) begin errors++; $display("FAIL initial_fetch_strobes: got rd_we=%b pc_we=%b expected 0 0", a_rd_we, a_pc_we); end
    apply_a(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we: got %b expected 1", a_rd_we); end
    checks++; if (a_rd_src !== 2'd1) begin errors++; $display("FAIL addi_rd_source: got %0d expected 1", a_rd_src); end
    checks++; if (a_pc_we !== 1'b1 || a_ias !== 1'b1) begin errors++; $display("FAIL addi_pc: got pc_we=%b ias=%b expected 1 1", a_pc_we, a_ias); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_retired !== 32'd1) begin errors++; $display("FAIL addi_retired: got %0d expected 1", a_retired); end
    checks++; if (a_rd_we !== 1'b0 || a_pc_we !== 1'b1) begin errors++; $display("FAIL fence_strobes: got rd_we=%b pc_we=%b expected 0 1", a_rd_we, a_pc_we); end
  endtask

  task automatic test_load();
    do_reset();
    apply_a(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd1 || a_pc_we !== 1'b0 || a_ias !== 1'b0) begin errors++; $display("FAIL lw_issue: got mem=%0d pc_we=%b ias=%b expected 1 0 0", a_mem, a_pc_we, a_ias); end
    apply_a(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd1 || a_pc_we !== 1'b0 || a_rd_we !== 1'b0) begin errors++; $display("FAIL lw_wait1: got mem=%0d pc_we=%b rd_we=%b expected 1 0 0", a_mem, a_pc_we, a_rd_we); end
    apply_a(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd1 || a_pc_we !== 1'b0) begin errors++; $display("FAIL lw_wait2: got mem=%0d pc_we=%b expected 1 0", a_mem, a_pc_we); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_rd_we !== 1'b1 || a_rd_src !== 2'd0) begin errors++; $display("FAIL lw_complete_rd: got rd_we=%b src=%0d expected 1 0", a_rd_we, a_rd_src); end
    checks++; if (a_pc_we !== 1'b1 || a_ias !== 1'b1 || a_mem !== 2'd1) begin errors++; $display("FAIL lw_complete_pc: got pc_we=%b ias=%b mem=%0d expected 1 1 1", a_pc_we, a_ias, a_mem); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_retired !== 32'd1) begin errors++; $display("FAIL lw_retired: got %0d expected 1", a_retired); end
  endtask

  task automatic test_ready_ignored();
    do_reset();
    apply_a(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b0);
    apply_a(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b0);
    checks++; if (a_pc_we !== 1'b0 || a_mem !== 2'd1) begin errors++; $display("FAIL early_ready_wait: got pc_we=%b mem=%0d expected 0 1", a_pc_we, a_mem); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_pc_we !== 1'b1 || a_rd_we !== 1'b1) begin errors++; $display("FAIL early_ready_complete: got pc_we=%b rd_we=%b expected 1 1", a_pc_we, a_rd_we); end
  endtask

  task automatic test_store_rmw();
    do_reset();
    apply_a(OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd2 || a_pc_we !== 1'b0) begin errors++; $display("FAIL sb_preload_issue: got mem=%0d pc_we=%b expected 2 0", a_mem, a_pc_we); end
    apply_a(OP_STORE, 3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd2 || a_pc_we !== 1'b0) begin errors++; $display("FAIL sb_preload_wait: got mem=%0d pc_we=%b expected 2 0", a_mem, a_pc_we); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd3 || a_pc_we !== 1'b1 || a_rd_we !== 1'b0) begin errors++; $display("FAIL sb_complete: got mem=%0d pc_we=%b rd_we=%b expected 3 1 0", a_mem, a_pc_we, a_rd_we); end
    apply_a(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd3 || a_pc_we !== 1'b1) begin errors++; $display("FAIL sw_single: got mem=%0d pc_we=%b expected 3 1", a_mem, a_pc_we); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_retired !== 32'd2) begin errors++; $display("FAIL store_retired: got %0d expected 2", a_retired); end
  endtask

  task automatic test_store_no_rmw();
    do_reset();
    apply_b(OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (b_mem !== 2'd3 || b_pc_we !== 1'b1 || b_rd_we !== 1'b0) begin errors++; $display("FAIL sb_norm: got mem=%0d pc_we=%b rd_we=%b expected 3 1 0", b_mem, b_pc_we, b_rd_we); end
    apply_b(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b_mem !== 2'd0 || b_pc_we !== 1'b1) begin errors++; $display("FAIL sb_norm_next: got mem=%0d pc_we=%b expected 0 1", b_mem, b_pc_we); end
  endtask

  task automatic test_timeout();
    do_reset();
    apply_b(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (b_mem !== 2'd1) begin errors++; $display("FAIL to_issue: got mem=%0d expected 1", b_mem); end
    for (int i = 1; i <= 3; i++) begin
      apply_b(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
      checks++; if (b_mem !== 2'd1 || b_halted !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got mem=%0d halted=%b expected 1 0", i, b_mem, b_halted); end
    end
    apply_b(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (b_mem !== 2'd0 || b_pc_we !== 1'b0 || b_rd_we !== 1'b0) begin errors++; $display("FAIL to_trigger: got mem=%0d pc_we=%b rd_we=%b expected 0 0 0", b_mem, b_pc_we, b_rd_we); end
    apply_b(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b_halted !== 1'b1 || b_cause !== 3'd5) begin errors++; $display("FAIL to_halt: got halted=%b cause=%0d expected 1 5", b_halted, b_cause); end
    checks++; if (b_retired !== 4'd0 || b_pc_we !== 1'b0) begin errors++; $display("FAIL to_no_commit: got retired=%0d pc_we=%b expected 0 0", b_retired, b_pc_we); end
  endtask

  task automatic test_halt_priority();
    int bad_cycles;
    do_reset();
    apply_a(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
    apply_a(OP_SYSTEM, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (a_pc_we !== 1'b0 || a_rd_we !== 1'b0 || a_mem !== 2'd0) begin errors++; $display("FAIL pcmis_trigger: got pc_we=%b rd_we=%b mem=%0d expected 0 0 0", a_pc_we, a_rd_we, a_mem); end
    apply_a(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_halted !== 1'b1 || a_cause !== 3'd2) begin errors++; $display("FAIL pcmis_cause: got halted=%b cause=%0d expected 1 2", a_halted, a_cause); end
    checks++; if (a_pc_we !== 1'b0 || a_retired !== 32'd1) begin errors++; $display("FAIL halt_frozen: got pc_we=%b retired=%0d expected 0 1", a_pc_we, a_retired); end
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      apply_a(OP_OPIMM, 3'd0, i[0], i[1], i[2]);
      if (a_halted !== 1'b1 || a_pc_we !== 1'b0 || a_cause !== 3'd2) bad_cycles++;
    end
    checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad_cycles); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_halted !== 1'b0 || a_cause !== 3'd0 || a_retired !== 32'd0) begin errors++; $display("FAIL halt_reset: got halted=%b cause=%0d retired=%0d expected 0 0 0", a_halted, a_cause, a_retired); end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_mem_unaligned();
    do_reset();
    apply_a(OP_SYSTEM, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (a_pc_we !== 1'b0) begin errors++; $display("FAIL memun_ecall_pc_we: got %b expected 0", a_pc_we); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_cause !== 3'd3) begin errors++; $display("FAIL memun_over_ecall: got cause=%0d expected 3", a_cause); end
    do_reset();
    apply_a(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    apply_a(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b1);
    checks++; if (a_mem !== 2'd0) begin errors++; $display("FAIL memun_wait_mem: got %0d expected 0", a_mem); end
    apply_a(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (a_cause !== 3'd3 || a_halted !== 1'b1 || a_rd_we !== 1'b0) begin errors++; $display("FAIL memun_wait_halt: got cause=%0d halted=%b rd_we=%b expected 3 1 0", a_cause, a_halted, a_rd_we); end
  endtask

  task automatic test_abort();
    do_reset();
    apply_a(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    apply_a(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    checks++; if (a_mem !== 2'd1) begin errors++; $display("FAIL abort_pre: got mem=%0d expected 1", a_mem); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (a_mem !== 2'd0 || a_pc_we !== 1'b0 || a_rd_we !== 1'b0) begin errors++; $display("FAIL abort_async: got mem=%0d pc_we=%b rd_we=%b expected 0 0 0", a_mem, a_pc_we, a_rd_we); end
    reset = 1'b0;
    apply_a(OP_FENCE, 3'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (a_retired !== 32'd0 || a_pc_we !== 1'b1 || a_rd_we !== 1'b0) begin errors++; $display("FAIL abort_after: got retired=%0d pc_we=%b rd_we=%b expected 0 1 0", a_retired, a_pc_we, a_rd_we); end
  endtask

  task automatic test_bad_opcode();
    do_reset();
    apply_b(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b_pc_we !== 1'b0 || b_rd_we !== 1'b0) begin errors++; $display("FAIL bad_trigger: got pc_we=%b rd_we=%b expected 0 0", b_pc_we, b_rd_we); end
    apply_b(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b_halted !== 1'b1 || b_cause !== 3'd4) begin errors++; $display("FAIL bad_cause: got halted=%b cause=%0d expected 1 4", b_halted, b_cause); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply_b(OP_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0);
      if (i == 16) begin
        checks++; if (b_retired !== 4'd0) begin errors++; $display("FAIL wrap_at_16: got %0d expected 0", b_retired); end
      end
    end
    apply_b(OP_FENCE, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b_retired !== 4'd1) begin errors++; $display("FAIL wrap_at_17: got %0d expected 1", b_retired); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_ready_ignored();
    test_store_rmw();
    test_store_no_rmw();
    test_timeout();
    test_halt_priority();
    test_mem_unaligned();
    test_abort();
    test_bad_opcode();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
